tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux.sv | 170 +++++++++++++++++
 tb/tb_tdm_demux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM frame demultiplexer.
// A sync-qualified bit starts a frame of NCH channels x W bits, MSB first,
// channel 0 first. The completed frame is presented on ch_data in one update
// with a single-cycle frame_valid pulse. Framing problems pulse err.
// Optional feature macro: TDM_DEMUX_PARITY_EN. When it is defined, each frame
// carries one trailing even-parity bit that covers all of its data bits.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [NCH*W-1:0]   ch_data,
  output logic               frame_valid,
  output logic               err,
  output logic               busy
);

  localparam int FW = NCH * W;
  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = $clog2(NCH);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [CW-1:0]   ch_cnt, ch_n;
  logic            par_ph, par_n;     // the next qualified bit is the parity bit
  logic [FW-1:0]   shadow, shadow_n;
  logic [FW-1:0]   ch_data_n;
  logic            fv_n, err_n;

  // Helper values: the shadow with the current bit written, a fresh frame,
  // and the counter values to use for advancing or restarting.
  logic [FW-1:0]   shadow_wr, shadow_st;
  logic [BW-1:0]   bit_adv, bit_st;
  logic [CW-1:0]   ch_adv, ch_st;
  logic            first_pos, last_pos;

  // Counters at 0/0 inside RECV means a frame has just completed.
  assign first_pos = (bit_cnt == '0) && (ch_cnt == '0) && !par_ph;
  assign last_pos  = (bit_cnt == BW'(W-1)) && (ch_cnt == CW'(NCH-1));

  // Write position: channel k occupies [k*W+W-1 : k*W], and its MSB arrives first.
  always_comb begin
    shadow_wr = shadow;
    for (int k = 0; k < FW; k++)
      if (k == int'(ch_cnt) * W + W - 1 - int'(bit_cnt)) shadow_wr[k] = din;
    shadow_st        = '0;
    shadow_st[W-1]   = din;
  end

  // Counter advance wraps both counters. A restart positions the counters just past channel 0's MSB.
  always_comb begin
    if (bit_cnt == BW'(W-1)) begin
      bit_adv = '0;
      ch_adv  = (ch_cnt == CW'(NCH-1)) ? '0 : ch_cnt + 1'b1;
    end else begin
      bit_adv = bit_cnt + 1'b1;
      ch_adv  = ch_cnt;
    end
    if (W == 1) begin
      bit_st = '0;
      ch_st  = CW'(1);
    end else begin
      bit_st = BW'(1);
      ch_st  = '0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_n;
  end

  // Datapath, counter and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      ch_cnt      <= '0;
      par_ph      <= 1'b0;
      shadow      <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      bit_cnt     <= bit_n;
      ch_cnt      <= ch_n;
      par_ph      <= par_n;
      shadow      <= shadow_n;
      ch_data     <= ch_data_n;
      frame_valid <= fv_n;
      err         <= err_n;
    end
  end

  // Next-state and datapath decisions; unqualified cycles change nothing
  always_comb begin
    state_n   = state;
    bit_n     = bit_cnt;
    ch_n      = ch_cnt;
    par_n     = par_ph;
    shadow_n  = shadow;
    ch_data_n = ch_data;
    fv_n      = 1'b0;
    err_n     = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (sync) begin
            state_n  = RECV;
            shadow_n = shadow_st;
            bit_n    = bit_st;
            ch_n     = ch_st;
          end
        end
        RECV: begin
          if (sync) begin
            // A sync bit on a frame boundary is expected. Any other sync bit is early,
            // even when it coincides with the last bit of the frame.
            err_n    = !first_pos;
            shadow_n = shadow_st;
            bit_n    = bit_st;
            ch_n     = ch_st;
            par_n    = 1'b0;
          end else if (first_pos) begin
            err_n   = 1'b1;
            state_n = HUNT;
          end
`ifdef TDM_DEMUX_PARITY_EN
          else if (par_ph) begin
            par_n = 1'b0;
            if (din == ^shadow) begin
              ch_data_n = shadow;
              fv_n      = 1'b1;
            end else begin
              err_n   = 1'b1;
              state_n = HUNT;
            end
          end
`endif
          else begin
            shadow_n = shadow_wr;
            bit_n    = bit_adv;
            ch_n     = ch_adv;
            if (last_pos) begin
`ifdef TDM_DEMUX_PARITY_EN
              par_n     = 1'b1;
`else
              ch_data_n = shadow_wr;
              fv_n      = 1'b1;
`endif
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = (state == RECV);
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: randomized scoreboard bench for tdm_demux (NCH=4, W=8).
module tb_tdm_demux;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int FW  = NCH * W;
`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, din = 1'b0, din_valid = 1'b0, sync = 1'b0;
  logic [FW-1:0] ch_data;
  logic          frame_valid, err, busy;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .ch_data(ch_data), .frame_valid(frame_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [FW-1:0] data; int unsigned cyc;} exp_t;
  exp_t sbq[$];

  // Reference model state: whether a frame is open, and how many of its bits have arrived.
  bit            in_frame = 1'b0;
  int            nbit = 0;
  logic [FW-1:0] acc = '0;
  int            err_exp = 0, err_seen = 0;
  int            checks = 0, errors = 0;
  logic [FW-1:0] cur = '0;
  int            gap_pct = 0;
  bit            alt = 1'b0, flip_par = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] place(input logic [FW-1:0] a, input int n, input logic b);
    int idx;
    logic [FW-1:0] one;
    idx = (n / W) * W + W - 1 - (n % W);
    one = {{(FW-1){1'b0}}, 1'b1} << idx;
    return b ? (a | one) : (a & ~one);
  endfunction

  task automatic push_exp();
    exp_t e;
    e.data = acc;
    e.cyc  = cyc;
    sbq.push_back(e);
  endtask

  // Frame-level rules: sync opens a frame; a frame ends after FW data bits (plus parity).
  task automatic model_bit(input logic b, input logic s);
    if (s) begin
      if (in_frame && nbit > 0) err_exp++;
      in_frame = 1'b1;
      acc      = place('0, 0, b);
      nbit     = 1;
    end else if (!in_frame) begin
      // discarded while hunting
    end else if (nbit == 0) begin
      err_exp++;
      in_frame = 1'b0;
    end else if (nbit == FW) begin
      if (b == ^acc) push_exp();
      else begin
        err_exp++;
        in_frame = 1'b0;
      end
      nbit = 0;
    end else begin
      acc  = place(acc, nbit, b);
      nbit++;
      if (nbit == FW && !PAR) begin
        push_exp();
        nbit = 0;
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    din_valid = 1'b0;
    din       = 1'($urandom_range(1));
    sync      = 1'($urandom_range(1));
  endtask

  task automatic send_bit(input logic b, input logic s);
    if (alt) idle_cycle();
    else while (int'($urandom_range(99)) < gap_pct) idle_cycle();
    @(negedge clk);
    din_valid = 1'b1;
    din       = b;
    sync      = s;
    @(posedge clk);
    #1;
    model_bit(b, s);
    din_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] d, input bit with_sync, input int nbits);
    logic [FW-1:0] t;
    for (int n = 0; n < nbits; n++) begin
      t = d >> ((n / W) * W + W - 1 - (n % W));
      send_bit(t[0], with_sync && (n == 0));
    end
    if (PAR && nbits == FW) send_bit((^d) ^ flip_par, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    in_frame = 1'b0;
    nbit     = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every frame_valid and checks the hold value otherwise.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_ch_data", 64'(ch_data), 64'(0));
      chk("reset_pulses", {62'd0, frame_valid, err}, 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      cur = '0;
    end else begin
      if (frame_valid && err) chk("fv_err_exclusive", 64'(1), 64'(0));
      if (err) err_seen++;
      if (frame_valid) begin
        if (sbq.size() == 0) chk("unexpected_frame_valid", 64'(ch_data), 64'(0));
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("frame_data", 64'(ch_data), 64'(e.data));
          chk("frame_latency", 64'(cyc), 64'(e.cyc));
          cur = e.data;
        end
      end else begin
        chk("ch_data_hold", 64'(ch_data), 64'(cur));
      end
      chk("busy", 64'(busy), 64'(in_frame));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    // single frame
    send_frame(32'h00FF3CA5, 1'b1, FW);
    repeat (3) idle_cycle();
    // back-to-back frames
    send_frame(32'h04030201, 1'b1, FW);
    send_frame(32'h44332211, 1'b1, FW);
    // early sync after 10 bits
    send_frame(32'($urandom), 1'b1, 10);
    send_frame(32'h78563412, 1'b1, FW);
    // din_valid low on every other cycle
    alt = 1'b1;
    send_frame(32'hDDCCBBAA, 1'b1, FW);
    alt = 1'b0;
    // missing sync right after a completed frame
    send_frame(32'($urandom), 1'b0, 5);
    send_frame(32'h0BADF00D, 1'b1, FW);
    // reset mid-frame, then unsynced frame, then synced frame
    send_frame(32'($urandom), 1'b1, 20);
    do_reset();
    send_frame(32'($urandom), 1'b0, FW);
    send_frame(32'hEEEEEEEE, 1'b1, FW);
    if (PAR) begin
      send_frame(32'h00000001, 1'b1, FW);
      flip_par = 1'b1;
      send_frame(32'h00000001, 1'b1, FW);
      flip_par = 1'b0;
    end
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r;
      r       = int'($urandom_range(9));
      gap_pct = int'($urandom_range(40));
      if (r < 6)       send_frame(32'($urandom), 1'b1, FW);
      else if (r == 6) send_frame(32'($urandom), 1'b1, int'($urandom_range(FW-1, 2)));
      else if (r == 7) send_frame(32'($urandom), 1'b0, int'($urandom_range(12, 1)));
      else if (r == 8) begin
        send_frame(32'($urandom), 1'b1, int'($urandom_range(FW-1, 1)));
        do_reset();
      end else begin
        flip_par = PAR && ($urandom_range(1) == 1);
        send_frame(32'($urandom), 1'b1, FW);
        flip_par = 1'b0;
      end
    end
    gap_pct = 0;
    repeat (4) idle_cycle();
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    chk("err_pulse_count", 64'(err_seen), 64'(err_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
